// File: rtl/cam_capture_pkg.sv
// rtl/cam_capture_pkg.sv - shared types and constants for the camera pixel capture block
// Contents:
//   cap_state_e   : capture FSM states
//   rgb565_t      : RGB565 pixel layout, R[15:11] G[10:5] B[4:0]
//   fifo_entry_w  : FIFO entry width for given coordinate widths (pixel + x + y + sof + eol)
package cam_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int unsigned PIX_W      = 16;
  localparam int unsigned XW_DEFAULT = 10;
  localparam int unsigned YW_DEFAULT = 9;

  function automatic int unsigned fifo_entry_w(input int unsigned xw, input int unsigned yw);
    return PIX_W + xw + yw + 2;
  endfunction

  localparam int unsigned FIFO_W_DEFAULT = fifo_entry_w(XW_DEFAULT, YW_DEFAULT);

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - synchronous show-ahead FIFO for captured pixel entries
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   s_tdata_i, s_tvalid_i : write side; a write while full is ignored
//   m_tdata_o, m_tready_i : read side; m_tdata_o shows the head entry, pop on m_tready_i when not empty
//   full_o, empty_o       : occupancy flags
//   count_o               : number of stored entries
module pix_fifo
  import cam_capture_pkg::*;
#(
  parameter int unsigned W     = FIFO_W_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [W-1:0]               s_tdata_i,
  input  logic                       s_tvalid_i,
  output logic [W-1:0]               m_tdata_o,
  input  logic                       m_tready_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_en;
  logic          rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr_en   = s_tvalid_i & ~full_o;
  assign rd_en   = m_tready_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_tdata_i;
  end

  assign m_tdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - OV-style byte stream framing, RGB565 pairing, optional 2x2 decimation
// Ports:
//   clk, reset                       : pixel clock (buffered cam_xclk), asynchronous active-high reset
//   enable                           : arm capture, sampled only at frame boundaries
//   cam_vsync, cam_href, cam_dat     : raw camera sync and byte bus
//   pix_data/x/y/sof/eol, pix_valid  : FIFO head, held stable until pix_ready
//   pix_ready                        : consumer accepts head
//   frame_done                       : one-cycle pulse when a captured frame ends
//   overflow, overflow_clr           : sticky drop flag and its clear
module cam_pixel_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned DECIMATE   = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XW         = XW_DEFAULT,
  parameter int unsigned YW         = YW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_dat,
  output logic [15:0]   pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          frame_done,
  output logic          overflow,
  input  logic          overflow_clr
);

  localparam int unsigned EW    = fifo_entry_w(XW, YW);
  localparam int unsigned EOL_X = H_ACTIVE - 1 - DECIMATE;

  // Input registers; vsync/href get a second stage for edge detection.
  logic       vsync_q, vsync_qq;
  logic       href_q, href_qq;
  logic [7:0] dat_q;
  logic       vs_rise;
  logic       href_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      dat_q    <= '0;
    end else begin
      vsync_q  <= cam_vsync;
      vsync_qq <= vsync_q;
      href_q   <= cam_href;
      href_qq  <= href_q;
      dat_q    <= cam_dat;
    end
  end

  assign vs_rise   = vsync_q & ~vsync_qq;
  assign href_fall = href_qq & ~href_q;

  cap_state_e    state_q, state_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          seen_q, seen_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q;
  logic          push;

  // Keep rule and sideband for the pixel being completed this cycle.
  logic [31:0]   x_ext, y_ext;
  logic          keep;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          sof_w, eol_w;
  rgb565_t       pix_word;
  logic [EW-1:0] wr_entry;

  assign x_ext    = 32'(x_q);
  assign y_ext    = 32'(y_q);
  assign keep     = (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE) &&
                    ((DECIMATE == 0) || (!x_q[0] && !y_q[0]));
  assign out_x    = x_q >> DECIMATE;
  assign out_y    = y_q >> DECIMATE;
  assign sof_w    = (out_x == '0) && (out_y == '0);
  assign eol_w    = (x_ext == EOL_X);
  assign pix_word = {hi_q, dat_q};
  assign wr_entry = {sof_w, eol_w, out_y, out_x, pix_word};

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    x_d          = x_q;
    y_d          = y_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (vs_rise) begin
          state_d = ST_CAPTURE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          seen_d  = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          frame_done_d = 1'b1;
          x_d          = '0;
          y_d          = '0;
          phase_d      = 1'b0;
          seen_d       = 1'b0;
          state_d      = enable ? ST_CAPTURE : ST_IDLE;
        end else if (href_q) begin
          seen_d = 1'b1;
          if (!phase_q) begin
            hi_d    = dat_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            push    = keep;
            // Saturate so over-long lines never wrap back into the active window.
            if (x_q != '1) x_d = x_q + 1'b1;
          end
        end else if (href_fall) begin
          // A dangling high byte is simply forgotten by clearing the phase.
          x_d     = '0;
          phase_d = 1'b0;
          seen_d  = 1'b0;
          if (seen_q && (y_q != '1)) y_d = y_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic [EW-1:0]                head;
  logic [EW-1:0]                head_gated;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      seen_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      x_q          <= x_d;
      y_q          <= y_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      // A drop in the same cycle as a clear leaves the flag set.
      if (push && fifo_full) overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  pix_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .s_tdata_i  (wr_entry),
    .s_tvalid_i (push),
    .m_tdata_o  (head),
    .m_tready_i (pix_ready),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Storage is not reset, so the head fields are forced to zero while nothing is stored.
  assign head_gated = (fifo_count != '0) ? head : '0;
  assign {pix_sof, pix_eol, pix_y, pix_x, pix_data} = head_gated;
  assign pix_valid  = ~fifo_empty;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb/tb_cam_pixel_capture.sv - directed self-checking bench for cam_pixel_capture
module tb_cam_pixel_capture;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int EW = 16 + XW + YW + 2;

  typedef logic [EW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en0 = 1'b0, en1 = 1'b0;
  logic          cam_vsync = 1'b0, cam_href = 1'b0;
  logic [7:0]    cam_dat = 8'h00;
  logic          rdy0 = 1'b1, rdy1 = 1'b1;
  logic          oclr = 1'b0;

  logic [15:0]   d0_data, d1_data;
  logic [XW-1:0] d0_x, d1_x;
  logic [YW-1:0] d0_y, d1_y;
  logic          d0_sof, d0_eol, d0_valid, d0_fd, d0_ovf;
  logic          d1_sof, d1_eol, d1_valid, d1_fd, d1_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cam_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIMATE(0), .FIFO_DEPTH(4), .XW(XW), .YW(YW)) dut0 (
    .clk(clk), .reset(reset), .enable(en0), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dat(cam_dat),
    .pix_data(d0_data), .pix_x(d0_x), .pix_y(d0_y), .pix_sof(d0_sof), .pix_eol(d0_eol), .pix_valid(d0_valid),
    .pix_ready(rdy0), .frame_done(d0_fd), .overflow(d0_ovf), .overflow_clr(oclr)
  );

  cam_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(4), .DECIMATE(1), .FIFO_DEPTH(4), .XW(XW), .YW(YW)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dat(cam_dat),
    .pix_data(d1_data), .pix_x(d1_x), .pix_y(d1_y), .pix_sof(d1_sof), .pix_eol(d1_eol), .pix_valid(d1_valid),
    .pix_ready(rdy1), .frame_done(d1_fd), .overflow(d1_ovf), .overflow_clr(oclr)
  );

  ent_t q0[$];
  ent_t q1[$];
  int   fd0 = 0, fd1 = 0;

  // Accepted beats are recorded just before the rising edge that pops them.
  always begin
    @(negedge clk);
    #4;
    if (d0_valid && rdy0) q0.push_back({d0_sof, d0_eol, d0_y, d0_x, d0_data});
    if (d1_valid && rdy1) q1.push_back({d1_sof, d1_eol, d1_y, d1_x, d1_data});
    if (d0_fd) fd0++;
    if (d1_fd) fd1++;
  end

  function automatic ent_t mk(input logic [15:0] d, input int x, input int y, input bit sof, input bit eol);
    return {sof, eol, YW'(y), XW'(x), d};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_line(input logic [7:0] b[$]);
    foreach (b[i]) begin
      cam_href = 1'b1;
      cam_dat  = b[i];
      @(negedge clk);
    end
    cam_href = 1'b0;
    cam_dat  = 8'h00;
    cyc(4);
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    cyc(3);
    cam_vsync = 1'b0;
    cyc(3);
  endtask

  task automatic do_reset();
    cam_href = 1'b0; cam_vsync = 1'b0; cam_dat = 8'h00;
    en0 = 1'b0; en1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1; oclr = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    cyc(3);
    checks++; if (d0_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", d0_valid); end
    checks++; if ({d0_sof, d0_eol, d0_y, d0_x, d0_data} !== '0) begin failures++; $display("FAIL reset_head got=%h exp=0", {d0_sof, d0_eol, d0_y, d0_x, d0_data}); end
    checks++; if ({d0_fd, d0_ovf, d1_valid, d1_fd, d1_ovf} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {d0_fd, d0_ovf, d1_valid, d1_fd, d1_ovf}); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_basic_frame();
    int base, fdb;
    logic [7:0] bl[$];
    logic [15:0] exp_d[4];
    ent_t got, exp;
    exp_d[0] = 16'hF800; exp_d[1] = 16'h07E0; exp_d[2] = 16'h001F; exp_d[3] = 16'hFFFF;
    do_reset();
    en0 = 1'b1;
    cyc(2);
    base = q0.size(); fdb = fd0;
    vsync_pulse();
    bl = {8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    send_line(bl);
    send_line(bl);
    vsync_pulse();
    cyc(2);
    checks++; if (q0.size() - base !== 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", q0.size() - base); end
    for (int i = 0; i < 8; i++) begin
      exp = mk(exp_d[i % 4], i % 4, i / 4, (i == 0), (i % 4 == 3));
      got = (base + i < q0.size()) ? q0[base + i] : 'x;
      checks++; if (got !== exp) begin failures++; $display("FAIL basic_pix%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if (fd0 - fdb !== 1) begin failures++; $display("FAIL basic_frame_done got=%0d exp=1", fd0 - fdb); end
  endtask

  task automatic test_overflow();
    int base;
    logic [7:0] bl[$];
    ent_t got, exp;
    do_reset();
    en0 = 1'b1;
    cyc(2);
    vsync_pulse();
    rdy0 = 1'b0;
    bl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    foreach (bl[i]) begin
      cam_href = 1'b1;
      cam_dat  = bl[i];
      @(negedge clk);
      if (i == 1) begin
        checks++; if (d0_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", d0_valid); end
      end
      if (i == 2) begin
        checks++; if (d0_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", d0_valid); end
      end
    end
    cam_href = 1'b0; cam_dat = 8'h00;
    cyc(4);
    checks++; if (d0_ovf !== 1'b0) begin failures++; $display("FAIL ovf_before_drop got=%b exp=0", d0_ovf); end
    bl = {8'h99, 8'hAA};
    send_line(bl);
    checks++; if ({d0_valid, d0_ovf} !== 2'b11) begin failures++; $display("FAIL ovf_set got=%b exp=11", {d0_valid, d0_ovf}); end
    exp = mk(16'h1122, 0, 0, 1'b1, 1'b0);
    checks++; if ({d0_sof, d0_eol, d0_y, d0_x, d0_data} !== exp) begin failures++; $display("FAIL hold_head got=%h exp=%h", {d0_sof, d0_eol, d0_y, d0_x, d0_data}, exp); end
    cyc(3);
    checks++; if ({d0_sof, d0_eol, d0_y, d0_x, d0_data} !== exp) begin failures++; $display("FAIL hold_stable got=%h exp=%h", {d0_sof, d0_eol, d0_y, d0_x, d0_data}, exp); end
    oclr = 1'b1;
    cyc(1);
    oclr = 1'b0;
    checks++; if (d0_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", d0_ovf); end
    base = q0.size();
    rdy0 = 1'b1;
    cyc(8);
    checks++; if (q0.size() - base !== 4) begin failures++; $display("FAIL drain_count got=%0d exp=4", q0.size() - base); end
    for (int i = 0; i < 4; i++) begin
      exp = mk({bl_hi(i), bl_hi(i) + 8'h11}, i, 0, (i == 0), (i == 3));
      got = (base + i < q0.size()) ? q0[base + i] : 'x;
      checks++; if (got !== exp) begin failures++; $display("FAIL drain_pix%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if (d0_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", d0_valid); end
  endtask

  // High byte of pixel i in the 11 22 33 44 ... line.
  function automatic logic [7:0] bl_hi(input int i);
    return 8'(8'h11 + 8'h22 * i);
  endfunction

  task automatic test_orphan_byte();
    int base, fdb;
    logic [7:0] bl[$];
    ent_t exp[3];
    ent_t got;
    exp[0] = mk(16'hAABB, 0, 0, 1'b1, 1'b0);
    exp[1] = mk(16'h0102, 0, 1, 1'b0, 1'b0);
    exp[2] = mk(16'h0304, 1, 1, 1'b0, 1'b0);
    do_reset();
    en0 = 1'b1;
    cyc(2);
    vsync_pulse();
    base = q0.size(); fdb = fd0;
    bl = {8'hAA, 8'hBB, 8'hCC};
    send_line(bl);
    bl = {8'h01, 8'h02, 8'h03, 8'h04};
    send_line(bl);
    vsync_pulse();
    cyc(2);
    checks++; if (q0.size() - base !== 3) begin failures++; $display("FAIL orphan_count got=%0d exp=3", q0.size() - base); end
    for (int i = 0; i < 3; i++) begin
      got = (base + i < q0.size()) ? q0[base + i] : 'x;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL orphan_pix%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (fd0 - fdb !== 1) begin failures++; $display("FAIL orphan_frame_done got=%0d exp=1", fd0 - fdb); end
  endtask

  task automatic test_decimate();
    int base, base0, fdb;
    logic [7:0] bl[$];
    ent_t exp[4];
    ent_t got;
    exp[0] = mk(16'h00C0, 0, 0, 1'b1, 1'b0);
    exp[1] = mk(16'h02C2, 1, 0, 1'b0, 1'b1);
    exp[2] = mk(16'h20C0, 0, 1, 1'b0, 1'b0);
    exp[3] = mk(16'h22C2, 1, 1, 1'b0, 1'b1);
    do_reset();
    en1 = 1'b1;
    cyc(2);
    vsync_pulse();
    base = q1.size(); base0 = q0.size(); fdb = fd1;
    for (int y = 0; y < 4; y++) begin
      bl = {};
      for (int x = 0; x < 4; x++) begin
        bl.push_back(8'(16 * y + x));
        bl.push_back(8'(8'hC0 + x));
      end
      send_line(bl);
    end
    vsync_pulse();
    cyc(2);
    checks++; if (q1.size() - base !== 4) begin failures++; $display("FAIL dec_count got=%0d exp=4", q1.size() - base); end
    for (int i = 0; i < 4; i++) begin
      got = (base + i < q1.size()) ? q1[base + i] : 'x;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL dec_pix%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (fd1 - fdb !== 1) begin failures++; $display("FAIL dec_frame_done got=%0d exp=1", fd1 - fdb); end
    checks++; if (q0.size() - base0 !== 0) begin failures++; $display("FAIL idle_unit_quiet got=%0d exp=0", q0.size() - base0); end
    en1 = 1'b0;
  endtask

  task automatic test_long_line_and_disable();
    int base, fdb;
    logic [7:0] bl[$];
    ent_t got, exp;
    do_reset();
    en0 = 1'b1;
    cyc(2);
    vsync_pulse();
    base = q0.size(); fdb = fd0;
    bl = {};
    for (int x = 0; x < 6; x++) begin
      bl.push_back(8'(8'h40 + x));
      bl.push_back(8'(8'h50 + x));
    end
    send_line(bl);
    en0 = 1'b0;
    bl = {8'h60, 8'h61, 8'h62, 8'h63};
    send_line(bl);
    vsync_pulse();
    cyc(2);
    checks++; if (q0.size() - base !== 6) begin failures++; $display("FAIL long_count got=%0d exp=6", q0.size() - base); end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp = mk({8'(8'h40 + i), 8'(8'h50 + i)}, i, 0, (i == 0), (i == 3));
      else       exp = mk((i == 4) ? 16'h6061 : 16'h6263, i - 4, 1, 1'b0, 1'b0);
      got = (base + i < q0.size()) ? q0[base + i] : 'x;
      checks++; if (got !== exp) begin failures++; $display("FAIL long_pix%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if (fd0 - fdb !== 1) begin failures++; $display("FAIL disable_frame_done got=%0d exp=1", fd0 - fdb); end
    base = q0.size(); fdb = fd0;
    send_line(bl);
    vsync_pulse();
    send_line(bl);
    vsync_pulse();
    cyc(2);
    checks++; if (q0.size() - base !== 0) begin failures++; $display("FAIL disabled_pixels got=%0d exp=0", q0.size() - base); end
    checks++; if (fd0 - fdb !== 0) begin failures++; $display("FAIL disabled_frame_done got=%0d exp=0", fd0 - fdb); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [7:0] bl[$];
    ent_t got, exp;
    do_reset();
    en0 = 1'b1;
    cyc(2);
    vsync_pulse();
    rdy0 = 1'b0;
    bl = {8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2};
    foreach (bl[i]) begin
      cam_href = 1'b1;
      cam_dat  = bl[i];
      @(negedge clk);
    end
    checks++; if (d0_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", d0_valid); end
    reset = 1'b1;
    #1;
    checks++; if ({d0_valid, d0_data} !== 17'h0) begin failures++; $display("FAIL async_reset got=%h exp=0", {d0_valid, d0_data}); end
    @(negedge clk);
    reset = 1'b0;
    rdy0 = 1'b1;
    base = q0.size();
    bl = {8'hD1, 8'hD2, 8'hE1, 8'hE2};
    send_line(bl);
    send_line(bl);
    checks++; if (q0.size() - base !== 0) begin failures++; $display("FAIL no_partial_frame got=%0d exp=0", q0.size() - base); end
    vsync_pulse();
    bl = {8'hF1, 8'hF2, 8'hF3, 8'hF4};
    send_line(bl);
    checks++; if (q0.size() - base !== 2) begin failures++; $display("FAIL post_reset_count got=%0d exp=2", q0.size() - base); end
    for (int i = 0; i < 2; i++) begin
      exp = mk((i == 0) ? 16'hF1F2 : 16'hF3F4, i, 0, (i == 0), 1'b0);
      got = (base + i < q0.size()) ? q0[base + i] : 'x;
      checks++; if (got !== exp) begin failures++; $display("FAIL post_reset_pix%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_orphan_byte();
    test_decimate();
    test_long_line_and_disable();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
